// File: rtl/aes_pkg.sv
// Shared types, constants and byte-level helpers for the iterative AES encryptor.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_e;

  localparam int AES_BLK = 128;
  localparam int CNT_W   = 4;

  function automatic int nr_of(input int klen);
    return klen / 32 + 6;
  endfunction

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (bypassed when final_rnd is high) and AddRoundKey. Byte b sits at bits [8b +: 8].
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [0:AES_BLK-1] state_in,
  input  logic [0:AES_BLK-1] rk,
  input  logic               final_rnd,
  output logic [0:AES_BLK-1] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int b = 0; b < 16; b++) sb[b] = sub_byte(state_in[8*b +: 8]);
    // Column-major state: row r of column c is byte 4c+r; row r rotates left by r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int b = 0; b < 16; b++)
      state_out[8*b +: 8] = (final_rnd ? sr[b] : mc[b]) ^ rk[8*b +: 8];
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor, one round per clock with valid/ready on both sides.
// Define AES_ITER_CBC_EN to add CBC chaining (iv / iv_load ports and a chain register).
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int key_length = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:AES_BLK-1]    plain_txt,
  input  logic [0:key_length-1] key,
`ifdef AES_ITER_CBC_EN
  input  logic [0:AES_BLK-1]    iv,
  input  logic                  iv_load,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:AES_BLK-1]    cipher_txt,
  output logic                  busy
);

  localparam int Nk = key_length / 32;
  localparam int Nr = nr_of(key_length);
  localparam int NW = 4 * (Nr + 1);

  if (key_length != 128 && key_length != 192 && key_length != 256) begin : g_bad_key
    $error("aes_encrypt_iter: key_length must be 128, 192 or 256");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:AES_BLK-1] pt_q, pt_d, blk_q, blk_d, cipher_q, cipher_d;
  logic [0:key_length-1] key_q, key_d;
  logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic [0:AES_BLK-1] chain_src;
  logic [31:0]        w [NW];
  logic [0:AES_BLK-1] rk_cur, rnd_out;
  logic [CNT_W-1:0]   rk_idx;

`ifdef AES_ITER_CBC_EN
  logic [0:AES_BLK-1] chain_q, chain_d;
  assign chain_src = iv_load ? iv : chain_q;
`else
  assign chain_src = '0;
`endif

  // Key schedule, combinational from the registered key.
  always_comb begin
    logic [31:0] t;
    logic [7:0]  rcon;
    t    = '0;
    rcon = 8'h01;
    for (int i = 0; i < Nk; i++) w[i] = key_q[32*i +: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
  end

  assign rk_idx = (state_q == ROUND) ? cnt_q : '0;

  always_comb begin
    rk_cur = '0;
    for (int i = 0; i <= Nr; i++)
      if (CNT_W'(i) == rk_idx) rk_cur = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  end

  aes_round_unit u_round (
    .state_in  (blk_q),
    .rk        (rk_cur),
    .final_rnd (cnt_q == CNT_W'(Nr)),
    .state_out (rnd_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pt_d        = pt_q;
    key_d       = key_q;
    blk_d       = blk_q;
    cipher_d    = cipher_q;
    out_valid_d = out_valid_q;
`ifdef AES_ITER_CBC_EN
    chain_d     = (state_q == IDLE && iv_load) ? iv : chain_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          pt_d    = plain_txt ^ chain_src;
          key_d   = key;
          state_d = INIT;
        end
      end
      INIT: begin
        blk_d   = pt_q ^ rk_cur;
        cnt_d   = CNT_W'(1);
        state_d = ROUND;
      end
      ROUND: begin
        blk_d = rnd_out;
        if (cnt_q == CNT_W'(Nr)) begin
          cipher_d    = rnd_out;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef AES_ITER_CBC_EN
          chain_d     = cipher_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cipher_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_ITER_CBC_EN
      chain_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cipher_q    <= cipher_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef AES_ITER_CBC_EN
      chain_q     <= chain_d;
`endif
    end
    pt_q  <= pt_d;
    key_q <= key_d;
    blk_q <= blk_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign cipher_txt = cipher_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed-vector bench for aes_encrypt_iter using FIPS-197 App.B/App.C known answers.
module tb_aes_encrypt_iter;

  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KC192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KC256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CC192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CC256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127] plain_txt, key, cipher_txt;
`ifdef AES_ITER_CBC_EN
  logic [0:127] iv;
  logic         iv_load;
`endif

  logic         x_in_valid, x_out_ready;
  logic [0:127] x_plain;
  logic [0:191] key192;
  logic [0:255] key256;
  logic         in_ready192, out_valid192, busy192;
  logic         in_ready256, out_valid256, busy256;
  logic [0:127] ct192, ct256;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  aes_encrypt_iter #(.key_length(128)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plain_txt(plain_txt), .key(key),
`ifdef AES_ITER_CBC_EN
    .iv(iv), .iv_load(iv_load),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .cipher_txt(cipher_txt), .busy(busy)
  );

  aes_encrypt_iter #(.key_length(192)) dut192 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(in_ready192),
    .plain_txt(x_plain), .key(key192),
`ifdef AES_ITER_CBC_EN
    .iv(128'h0), .iv_load(1'b1),
`endif
    .out_valid(out_valid192), .out_ready(x_out_ready), .cipher_txt(ct192), .busy(busy192)
  );

  aes_encrypt_iter #(.key_length(256)) dut256 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(in_ready256),
    .plain_txt(x_plain), .key(key256),
`ifdef AES_ITER_CBC_EN
    .iv(128'h0), .iv_load(1'b1),
`endif
    .out_valid(out_valid256), .out_ready(x_out_ready), .cipher_txt(ct256), .busy(busy256)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one block, wait for the result and check latency and ciphertext.
  task automatic run128(input string tag, input logic [127:0] k, input logic [127:0] p,
                        input logic [127:0] exp, output int t_acc);
    int n;
    key       = k;
    plain_txt = p;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    step();
    t_acc    = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk({tag, "_latency"}, 128'(n), 128'd11);
    chk({tag, "_cipher"}, cipher_txt, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tp, n, lat192, lat256;
    logic [127:0] got192, got256;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plain_txt = '0; key = '0;
    x_in_valid = 1'b0; x_out_ready = 1'b1; x_plain = '0; key192 = '0; key256 = '0;
`ifdef AES_ITER_CBC_EN
    iv = '0; iv_load = 1'b1;
`endif
    step(); step();
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_cipher", cipher_txt, 128'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // App.B with five cycles of backpressure
    run128("appb", KB, PB, CB, t);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_cipher", cipher_txt, CB);
    end
    out_ready = 1'b1;
    step();
    chk("hs_out_valid", 128'(out_valid), 128'd0);
    chk("hs_in_ready", 128'(in_ready), 128'd1);
    chk("hs_busy", 128'(busy), 128'd0);

    run128("appc128", KC128, PC, CC128, t);

    // Back-to-back streaming with out_ready held high
    tp = 0;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) run128("stream", KB, PB, CB, t);
      else            run128("stream", KC128, PC, CC128, t);
      if (j > 0) chk("stream_gap", 128'(t - tp), 128'd13);
      tp = t;
    end

    // Reset while the round counter sits at 5
    key = KB; plain_txt = PB; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_cipher", cipher_txt, 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    step();
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    run128("appb_after_rst", KB, PB, CB, t);

    // App.C for the 192- and 256-bit instances, started on the same edge
    x_plain = PC; key192 = KC192; key256 = KC256; x_in_valid = 1'b1;
    chk("x_in_ready192", 128'(in_ready192), 128'd1);
    chk("x_in_ready256", 128'(in_ready256), 128'd1);
    step();
    x_in_valid = 1'b0;
    lat192 = 0; lat256 = 0; got192 = '0; got256 = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid192 && lat192 == 0) begin lat192 = i; got192 = ct192; end
      if (out_valid256 && lat256 == 0) begin lat256 = i; got256 = ct256; end
    end
    chk("appc192_latency", 128'(lat192), 128'd13);
    chk("appc192_cipher", got192, CC192);
    chk("appc256_latency", 128'(lat256), 128'd15);
    chk("appc256_cipher", got256, CC256);

`ifdef AES_ITER_CBC_EN
    // Chained block: plaintext pre-masked with the previous ciphertext re-creates App.B
    run128("cbc1", KB, PB, CB, t);
    iv_load = 1'b0;
    run128("cbc2", KB, PB ^ CB, CB, t);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
